// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: FSM encoding, register map
// and CTRL field positions.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

  localparam logic [1:0] MODE_RELOAD = 2'd1;

  // Assemble the readable CTRL word; unused upper bits read as zero.
  function automatic logic [31:0] pack_ctrl(input logic en, input logic [1:0] mode,
                                            input logic im);
    logic [31:0] w;
    w = 32'd0;
    w[CTRL_EN_BIT] = en;
    w[CTRL_MODE_MSB:CTRL_MODE_LSB] = mode;
    w[CTRL_IM_BIT] = im;
    return w;
  endfunction

endpackage

// File: rtl/countdown_timer.sv
// Memory-mapped 32-bit countdown timer with one-shot or auto-reload mode and
// a maskable registered interrupt.
module countdown_timer
  import timer_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  output logic        IRQ
);

  state_t      state_r;
  logic        enable_r;
  logic [1:0]  mode_r;
  logic        im_r;
  logic [31:0] preset_r;
  logic [31:0] count_r;
  logic        irq_flag_r;

  // Register file and FSM; bus writes are issued last so they win over the FSM.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r    <= ST_IDLE;
      enable_r   <= 1'b0;
      mode_r     <= 2'd0;
      im_r       <= 1'b0;
      preset_r   <= 32'd0;
      count_r    <= 32'd0;
      irq_flag_r <= 1'b0;
      IRQ        <= 1'b0;
    end else begin
      IRQ <= irq_flag_r & im_r;

      case (state_r)
        ST_IDLE: begin
          if (enable_r) begin
            state_r <= ST_LOAD;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          count_r <= preset_r;
          state_r <= ST_CNT;
        end
        ST_CNT: begin
          if (!enable_r) begin
            state_r <= ST_IDLE;
          end else if (count_r > 32'd1) begin
            count_r <= count_r - 32'd1;
          end else begin
            // A zero preset expires on the first counting cycle, like a preset of one.
            count_r    <= 32'd0;
            irq_flag_r <= 1'b1;
            state_r    <= ST_INT;
          end
        end
        ST_INT: begin
          if (mode_r == MODE_RELOAD) begin
            irq_flag_r <= 1'b0;
            state_r    <= ST_LOAD;
          end else begin
            enable_r <= 1'b0;
            state_r  <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase

      if (WE) begin
        case (Addr)
          ADDR_CTRL: begin
            enable_r   <= DIn[CTRL_EN_BIT];
            mode_r     <= DIn[CTRL_MODE_MSB:CTRL_MODE_LSB];
            im_r       <= DIn[CTRL_IM_BIT];
            irq_flag_r <= 1'b0;
          end
          ADDR_PRESET: begin
            preset_r   <= DIn;
            irq_flag_r <= 1'b0;
          end
          default: begin
          end
        endcase
      end else begin
      end
    end
  end

  // Combinational read mux.
  always_comb begin
    DOut = 32'd0;
    case (Addr)
      ADDR_CTRL:   DOut = pack_ctrl(enable_r, mode_r, im_r);
      ADDR_PRESET: DOut = preset_r;
      ADDR_COUNT:  DOut = count_r;
      ADDR_RSVD:   DOut = 32'd0;
      default:     DOut = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized bench for countdown_timer: a cycle-level reference model checks
// every register and IRQ after each edge, plus directed scenario checks.
module tb_countdown_timer;

  logic        Clk;
  logic        Reset;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] DIn;
  logic [31:0] DOut;
  logic        IRQ;

  int n_cmp;
  int n_err;

  countdown_timer dut (
    .Clk  (Clk),
    .Reset(Reset),
    .Addr (Addr),
    .WE   (WE),
    .DIn  (DIn),
    .DOut (DOut),
    .IRQ  (IRQ)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: the timer as a set of named registers plus an activity phase.
  localparam int PH_STOPPED = 0;  // waiting for Enable
  localparam int PH_ARMING  = 1;  // next cycle copies PRESET into COUNT
  localparam int PH_RUNNING = 2;  // counting down
  localparam int PH_FIRED   = 3;  // expiry cycle just happened

  int          m_phase;
  bit          m_en;
  int          m_mode;
  bit          m_im;
  longint      m_preset;
  longint      m_count;
  bit          m_flag;
  bit          m_irq;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One rising edge of the model, given the inputs present at that edge.
  task automatic model_edge(input bit rst, input bit we, input int a, input longint d);
    int     ph;
    bit     en, flag;
    longint cnt;
    if (rst) begin
      m_phase = PH_STOPPED; m_en = 0; m_mode = 0; m_im = 0;
      m_preset = 0; m_count = 0; m_flag = 0; m_irq = 0;
      return;
    end
    m_irq = m_flag && m_im;
    ph = m_phase; en = m_en; flag = m_flag; cnt = m_count;
    if (m_phase == PH_STOPPED) begin
      if (m_en) ph = PH_ARMING;
    end else if (m_phase == PH_ARMING) begin
      cnt = m_preset; ph = PH_RUNNING;
    end else if (m_phase == PH_RUNNING) begin
      if (!m_en) ph = PH_STOPPED;
      else if (m_count >= 2) cnt = m_count - 1;
      else begin cnt = 0; flag = 1; ph = PH_FIRED; end
    end else begin
      if (m_mode == 1) begin flag = 0; ph = PH_ARMING; end
      else begin en = 0; ph = PH_STOPPED; end
    end
    if (we && a == 0) begin
      en = d[0]; m_mode = int'((d >> 1) & 3); m_im = d[3]; flag = 0;
    end
    if (we && a == 1) begin
      m_preset = d & 64'hFFFF_FFFF; flag = 0;
    end
    m_phase = ph; m_en = en; m_flag = flag; m_count = cnt;
  endtask

  task automatic peek(input logic [1:0] a, output logic [31:0] v);
    Addr = a;
    #1;
    v = DOut;
  endtask

  // Apply one cycle of stimulus, then compare all readable state with the model.
  task automatic cycle(input bit rst, input bit we, input logic [1:0] a, input logic [31:0] d);
    logic [31:0] v;
    longint      exp_ctrl;
    Reset = rst; WE = we; Addr = a; DIn = d;
    @(posedge Clk);
    model_edge(rst, we, int'(a), longint'(d));
    #1;
    Reset = 1'b0; WE = 1'b0;
    check_val("irq", {31'd0, IRQ}, {31'd0, m_irq});
    exp_ctrl = longint'(m_en) + longint'(m_mode) * 2 + longint'(m_im) * 8;
    peek(2'd0, v); check_val("ctrl", v, exp_ctrl[31:0]);
    peek(2'd1, v); check_val("preset", v, m_preset[31:0]);
    peek(2'd2, v); check_val("count", v, m_count[31:0]);
    peek(2'd3, v); check_val("rsvd", v, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  logic [31:0] v;
  int          exp_cnt_seq [8];
  bit          exp_irq_seq [8];

  initial begin
    n_cmp = 0; n_err = 0;
    Reset = 1'b0; WE = 1'b0; Addr = 2'd0; DIn = 32'd0;
    m_phase = PH_STOPPED; m_en = 0; m_mode = 0; m_im = 0;
    m_preset = 0; m_count = 0; m_flag = 0; m_irq = 0;
    #2;

    // Reset state, reserved and COUNT writes ignored.
    cycle(1'b1, 1'b0, 2'd0, 32'd0);
    check_val("rst_irq", {31'd0, IRQ}, 32'd0);
    peek(2'd0, v); check_val("rst_ctrl", v, 32'd0);
    cycle(1'b0, 1'b1, 2'd2, 32'h55);
    cycle(1'b0, 1'b1, 2'd3, 32'hFFFF_FFFF);
    peek(2'd2, v); check_val("count_ro", v, 32'd0);
    peek(2'd3, v); check_val("rsvd_ro", v, 32'd0);
    cycle(1'b0, 1'b1, 2'd0, 32'hFFFF_FFF0 | 32'h8);
    peek(2'd0, v); check_val("ctrl_upper0", v, 32'h8);

    // One-shot, PRESET=3, IM=1.
    cycle(1'b1, 1'b0, 2'd0, 32'd0);
    cycle(1'b0, 1'b1, 2'd1, 32'd3);
    cycle(1'b0, 1'b1, 2'd0, 32'h9);
    exp_cnt_seq = '{0, 0, 3, 2, 1, 0, 0, 0};
    exp_irq_seq = '{0, 0, 0, 0, 0, 0, 1, 1};
    for (int k = 1; k <= 7; k++) begin
      cycle(1'b0, 1'b0, 2'd0, 32'd0);
      check_val($sformatf("os_irq_e%0d", k), {31'd0, IRQ}, {31'd0, exp_irq_seq[k]});
      peek(2'd2, v); check_val($sformatf("os_cnt_e%0d", k), v, exp_cnt_seq[k]);
    end
    peek(2'd0, v); check_val("os_en_cleared", v, 32'h8);

    // Clearing via CTRL write drops IRQ one cycle later.
    cycle(1'b0, 1'b1, 2'd0, 32'h8);
    check_val("clr_irq_same", {31'd0, IRQ}, 32'd1);
    cycle(1'b0, 1'b0, 2'd0, 32'd0);
    check_val("clr_irq_next", {31'd0, IRQ}, 32'd0);
    peek(2'd2, v); check_val("clr_cnt", v, 32'd0);

    // Auto-reload, PRESET=2: pulses at edges 5, 9, 13, ...
    cycle(1'b1, 1'b0, 2'd0, 32'd0);
    cycle(1'b0, 1'b1, 2'd1, 32'd2);
    cycle(1'b0, 1'b1, 2'd0, 32'hB);
    for (int k = 1; k <= 16; k++) begin
      cycle(1'b0, 1'b0, 2'd0, 32'd0);
      check_val($sformatf("ar_irq_e%0d", k), {31'd0, IRQ},
                (k >= 5 && (k - 5) % 4 == 0) ? 32'd1 : 32'd0);
    end

    // PRESET=0 expires on the first counting cycle, as PRESET=1 does.
    cycle(1'b1, 1'b0, 2'd0, 32'd0);
    cycle(1'b0, 1'b1, 2'd0, 32'h9);
    for (int k = 1; k <= 5; k++) begin
      cycle(1'b0, 1'b0, 2'd0, 32'd0);
      check_val($sformatf("p0_irq_e%0d", k), {31'd0, IRQ}, (k >= 4) ? 32'd1 : 32'd0);
    end

    // Disable mid-count freezes COUNT; reset mid-count with a write clears everything.
    cycle(1'b1, 1'b0, 2'd0, 32'd0);
    cycle(1'b0, 1'b1, 2'd1, 32'd100);
    cycle(1'b0, 1'b1, 2'd0, 32'h1);
    idle(10);
    cycle(1'b0, 1'b1, 2'd0, 32'h0);
    idle(5);
    peek(2'd2, v); check_val("frz_cnt", v, 32'd91);
    check_val("frz_irq", {31'd0, IRQ}, 32'd0);
    cycle(1'b0, 1'b1, 2'd0, 32'h9);
    idle(3);
    cycle(1'b1, 1'b1, 2'd0, 32'hF);
    for (int a = 0; a < 4; a++) begin
      peek(a[1:0], v); check_val($sformatf("rst_reg%0d", a), v, 32'd0);
    end
    idle(4);
    check_val("rst_no_irq", {31'd0, IRQ}, 32'd0);

    // Masked expiry, then unmasking via CTRL write also clears the flag.
    cycle(1'b0, 1'b1, 2'd1, 32'd2);
    cycle(1'b0, 1'b1, 2'd0, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b0, 1'b0, 2'd0, 32'd0);
      check_val($sformatf("mask_irq_e%0d", k), {31'd0, IRQ}, 32'd0);
    end
    cycle(1'b0, 1'b1, 2'd0, 32'h8);
    for (int k = 1; k <= 3; k++) begin
      cycle(1'b0, 1'b0, 2'd0, 32'd0);
      check_val($sformatf("unmask_irq_e%0d", k), {31'd0, IRQ}, 32'd0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 2)       cycle(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
      else if (r < 10) cycle(1'b0, 1'b1, 2'd0, ($urandom & 32'hFFFF_FFF0) | 32'($urandom_range(0, 15)));
      else if (r < 15) cycle(1'b0, 1'b1, 2'd1, 32'($urandom_range(0, 6)));
      else if (r < 18) cycle(1'b0, 1'b1, 2'($urandom_range(2, 3)), $urandom);
      else             cycle(1'b0, 1'b0, 2'($urandom_range(0, 3)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
